// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM states, owner tag and
// the latched memory request.
package cache_mem_arbiter_pkg;

   localparam int unsigned ARB_LINE_W = 256;
   localparam int unsigned ARB_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0] addr;
      logic                  read;
      logic                  write;
      logic [ARB_LINE_W-1:0] wdata;
   } mem_req_t;

   // Debug grant encoding: 00 idle, 01 I-cache owns the port, 10 D-cache owns it.
   function automatic logic [1:0] grant_code(input arb_state_t s);
      logic [1:0] g;
      g = 2'b00;
      case (s)
         BUSY_I:  g = 2'b01;
         BUSY_D:  g = 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick between the I-cache and
// D-cache requests. On a tie the requester that was not served last wins.
module cache_mem_arbiter_rr_arb2
   import cache_mem_arbiter_pkg::*;
(
   input  logic       req_i,
   input  logic       req_d,
   input  arb_owner_t last,
   output logic       valid,
   output arb_owner_t win
);

   // Winner selection; win is only meaningful while valid is high.
   always_comb begin
      valid = req_i | req_d;
      win   = OWN_I;
      if (req_i && req_d) begin
         win = (last == OWN_I) ? OWN_D : OWN_I;
      end else if (req_d) begin
         win = OWN_D;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single line-granular memory port between the I-cache and the
// D-cache. One transaction at a time; the winning request is latched in IDLE,
// the memory port is driven only from that latch while busy, and the memory
// response is routed back to the owner in the same cycle it arrives.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner
// BUSY_I | I-cache line read in flight, waiting for dfp_resp
// BUSY_D | D-cache read or writeback in flight, waiting for dfp_resp
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int unsigned LINE_W = ARB_LINE_W,
   parameter int unsigned ADDR_W = ARB_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic [ADDR_W-1:0] i_raddr,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] dfp_addr,
   output logic              dfp_read,
   output logic              dfp_write,
   output logic [LINE_W-1:0] dfp_wdata,
   input  logic [LINE_W-1:0] dfp_rdata,
   input  logic [ADDR_W-1:0] dfp_raddr,
   input  logic              dfp_resp,
   output logic [1:0]        grant
);

   arb_state_t state_q, state_d;
   arb_owner_t last_q, last_d;
   mem_req_t   req_q, req_d;
   logic       pick_valid;
   arb_owner_t pick_win;

   cache_mem_arbiter_rr_arb2 u_rr_arb2 (
      .req_i (i_read),
      .req_d (d_read | d_write),
      .last  (last_q),
      .valid (pick_valid),
      .win   (pick_win)
   );

   // State, last-served owner and the latched request; reset drops the port at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= OWN_I;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         req_q   <= req_d;
      end
   end

   // Next state, request latch and response routing.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      req_d   = req_q;
      i_resp  = 1'b0;
      d_resp  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               if (pick_win == OWN_D) begin
                  req_d.addr  = d_addr;
                  req_d.write = d_write;
                  req_d.read  = ~d_write;
                  req_d.wdata = d_wdata;
                  state_d     = BUSY_D;
               end else begin
                  req_d.addr  = i_addr;
                  req_d.write = 1'b0;
                  req_d.read  = 1'b1;
                  req_d.wdata = '0;
                  state_d     = BUSY_I;
               end
            end
         end
         BUSY_I: begin
            // A flushed I-cache has dropped i_read; the line is drained silently.
            if (dfp_resp) begin
               i_resp  = i_read;
               last_d  = OWN_I;
               state_d = IDLE;
            end
         end
         BUSY_D: begin
            if (dfp_resp) begin
               d_resp  = 1'b1;
               last_d  = OWN_D;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory port is driven purely from the latch; read data is passed straight through.
   always_comb begin
      dfp_addr  = req_q.addr;
      dfp_wdata = req_q.wdata;
      dfp_read  = (state_q != IDLE) && req_q.read;
      dfp_write = (state_q != IDLE) && req_q.write;
      grant     = grant_code(state_q);
      i_rdata   = dfp_rdata;
      i_raddr   = dfp_raddr;
      d_rdata   = dfp_rdata;
   end

   // D-cache must never ask for a read and a writeback at once; write wins if it does.
   d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule
